// File: rtl/logic_op_arbiter.sv
// logic_op_arbiter
// Shares one bitwise logic unit among N_REQ requesters. A rotating-priority
// arbiter grants at most one request per cycle, and the granted operation's
// result is captured in a single output register. That register is held
// until downstream accepts it. Retire and refill can happen on the same edge,
// so a continuously draining consumer sees one result per cycle.

module logic_op_arbiter #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 8,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [3*N_REQ-1:0]     req_op,
   input  logic [WIDTH*N_REQ-1:0] req_a,
   input  logic [WIDTH*N_REQ-1:0] req_b,
   output logic [N_REQ-1:0]       req_ready,
   output logic                   resp_valid,
   input  logic                   resp_ready,
   output logic [WIDTH-1:0]       resp_data,
   output logic [ID_W-1:0]        resp_id,
   output logic                   resp_err
);

   // Opcode encoding of the shared logic unit; 6 and 7 are illegal.
   typedef enum logic [2:0] {
      OP_AND  = 3'd0,
      OP_OR   = 3'd1,
      OP_NOTA = 3'd2,
      OP_XOR  = 3'd3,
      OP_XNOR = 3'd4,
      OP_NAND = 3'd5
   } op_e;

   // EMPTY: result register holds nothing. FULL: result waits for downstream.
   typedef enum logic {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } state_e;

   state_e            state_q;
   logic [ID_W-1:0]   prio_q;
   logic [WIDTH-1:0]  resp_data_q;
   logic [ID_W-1:0]   resp_id_q;
   logic              resp_err_q;

   logic [WIDTH-1:0]  resp_data_d;
   logic              resp_err_d;
   logic [ID_W-1:0]   prio_d;

   logic              slot_free;
   logic              grant;
   logic              grant_vld;
   logic [ID_W-1:0]   grant_idx;
   int                cand;

   logic [2:0]        sel_op;
   logic [WIDTH-1:0]  sel_a;
   logic [WIDTH-1:0]  sel_b;

   // The result slot can take a new entry if it is empty or being drained now.
   assign slot_free = (state_q == S_EMPTY) || resp_ready;

   // Rotating-priority search: first valid requester at or after prio_q.
   always_comb begin
      // NOTE: every combinational output gets a default before any branch,
      // otherwise a path that skips the assignment infers a latch.
      grant_vld = 1'b0;
      grant_idx = '0;
      cand      = 0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = int'(prio_q) + k;
         if (cand >= N_REQ) begin
            cand = cand - N_REQ;
         end
         if (!grant_vld && req_valid[cand[ID_W-1:0]]) begin
            grant_vld = 1'b1;
            grant_idx = cand[ID_W-1:0];
         end
      end
   end

   // A grant happens only when there is a request, a free slot and no reset.
   assign grant     = grant_vld && slot_free && !rst;
   assign req_ready = grant ? (N_REQ'(1) << grant_idx) : '0;

   // Route the granted requester's opcode and operands to the logic unit.
   always_comb begin
      sel_op = '0;
      sel_a  = '0;
      sel_b  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant_idx == ID_W'(i)) begin
            sel_op = req_op[3*i +: 3];
            sel_a  = req_a[WIDTH*i +: WIDTH];
            sel_b  = req_b[WIDTH*i +: WIDTH];
         end
      end
   end

   // Shared bitwise logic unit; illegal opcodes yield zero with an error flag.
   always_comb begin
      resp_data_d = '0;
      resp_err_d  = 1'b0;
      case (sel_op)
         OP_AND:  resp_data_d = sel_a & sel_b;
         OP_OR:   resp_data_d = sel_a | sel_b;
         OP_NOTA: resp_data_d = ~sel_a;
         OP_XOR:  resp_data_d = sel_a ^ sel_b;
         OP_XNOR: resp_data_d = ~(sel_a ^ sel_b);
         OP_NAND: resp_data_d = ~(sel_a & sel_b);
         default: begin
            resp_data_d = '0;
            resp_err_d  = 1'b1;
         end
      endcase
   end

   // Priority moves to the requester just after the one granted, wrapping.
   always_comb begin
      if (grant_idx == ID_W'(N_REQ - 1)) begin
         prio_d = '0;
      end else begin
         prio_d = grant_idx + 1'b1;
      end
   end

   // Result-register FSM: load on grant, retire on accept, freeze otherwise.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (rst) begin
         // NOTE: the payload registers are reset too, because the outputs are
         // required to read all-zero straight after reset, not just invalid.
         state_q     <= S_EMPTY;
         prio_q      <= '0;
         resp_data_q <= '0;
         resp_id_q   <= '0;
         resp_err_q  <= 1'b0;
      end else begin
         if (grant) begin
            resp_data_q <= resp_data_d;
            resp_id_q   <= grant_idx;
            resp_err_q  <= resp_err_d;
            prio_q      <= prio_d;
         end
         case (state_q)
            S_EMPTY: begin
               if (grant) begin
                  state_q <= S_FULL;
               end
            end
            S_FULL: begin
               if (!grant && resp_ready) begin
                  state_q <= S_EMPTY;
               end
            end
            default: state_q <= S_EMPTY;
         endcase
      end
   end

   assign resp_valid = (state_q == S_FULL);
   assign resp_data  = resp_data_q;
   assign resp_id    = resp_id_q;
   assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Testbench for logic_op_arbiter: opcode table, directed multi-cycle corner
// cases, and randomized traffic checked against a cycle-level reference model.

module tb_logic_op_arbiter;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int IW = 2;

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp_data;
      logic         exp_err;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // Per-requester stimulus, packed into the flat DUT buses below.
   logic         r_valid [N];
   logic [2:0]   r_op    [N];
   logic [W-1:0] r_a     [N];
   logic [W-1:0] r_b     [N];

   logic [N-1:0]   req_valid;
   logic [3*N-1:0] req_op;
   logic [W*N-1:0] req_a;
   logic [W*N-1:0] req_b;
   logic [N-1:0]   req_ready;
   logic           resp_valid;
   logic           resp_ready;
   logic [W-1:0]   resp_data;
   logic [IW-1:0]  resp_id;
   logic           resp_err;

   always_comb begin
      req_valid = '0;
      req_op    = '0;
      req_a     = '0;
      req_b     = '0;
      for (int i = 0; i < N; i++) begin
         req_valid[i]     = r_valid[i];
         req_op[3*i +: 3] = r_op[i];
         req_a[W*i +: W]  = r_a[i];
         req_b[W*i +: W]  = r_b[i];
      end
   end

   logic_op_arbiter #(.N_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_id    (resp_id),
      .resp_err   (resp_err)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: the result slot and the rotating priority pointer.
   bit           m_valid;
   logic [W-1:0] m_data;
   int           m_id;
   bit           m_err;
   int           m_ptr;

   function automatic logic [W-1:0] ref_op(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
      case (op)
         0:       return a & b;
         1:       return a | b;
         2:       return ~a;
         3:       return a ^ b;
         4:       return ~(a ^ b);
         5:       return ~(a & b);
         default: return '0;
      endcase
   endfunction

   // Which requester the rules say is granted now (-1 for none).
   function automatic int ref_pick();
      if (rst) return -1;
      if (m_valid && !resp_ready) return -1;
      for (int k = 0; k < N; k++) begin
         if (r_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
      end
      return -1;
   endfunction

   // One clock: compare at the falling edge, then advance the model.
   task automatic cycle(output int g);
      logic [N-1:0] exp_ready;
      logic [N-1:0] one;
      int           op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      bit           rr;
      bit           rs;
      @(negedge clk);
      one = 1;
      g   = ref_pick();
      exp_ready = (g >= 0) ? (one << g) : '0;
      check("req_ready", 32'(req_ready), 32'(exp_ready));
      check("resp_valid", 32'(resp_valid), 32'(m_valid));
      if (m_valid) begin
         check("resp_data", 32'(resp_data), 32'(m_data));
         check("resp_id", 32'(resp_id), m_id);
         check("resp_err", 32'(resp_err), 32'(m_err));
      end
      op = 0; a = '0; b = '0;
      if (g >= 0) begin
         op = int'(r_op[g]); a = r_a[g]; b = r_b[g];
      end
      rr = resp_ready;
      rs = rst;
      @(posedge clk);
      #1;
      if (rs) begin
         m_valid = 0; m_data = '0; m_id = 0; m_err = 0; m_ptr = 0;
      end else if (g >= 0) begin
         m_valid = 1;
         m_data  = ref_op(op, a, b);
         m_id    = g;
         m_err   = (op > 5);
         m_ptr   = (g + 1) % N;
      end else if (rr) begin
         m_valid = 0;
      end
   endtask

   task automatic reset_dut();
      int g;
      rst = 1'b1;
      cycle(g);
      cycle(g);
      rst = 1'b0;
   endtask

   task automatic clear_reqs();
      for (int i = 0; i < N; i++) r_valid[i] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t         tbl [8];
      int           g;
      logic [W-1:0] held_data;
      int           held_id;
      int           nxt;
      logic [N-1:0] one;
      int           wrap_exp [3];
      int           waits [N];

      tbl[0] = '{3'd0, 8'hAA, 8'h0F, 8'h0A, 1'b0};
      tbl[1] = '{3'd1, 8'hAA, 8'h0F, 8'hAF, 1'b0};
      tbl[2] = '{3'd2, 8'hAA, 8'h0F, 8'h55, 1'b0};
      tbl[3] = '{3'd3, 8'hAA, 8'h0F, 8'hA5, 1'b0};
      tbl[4] = '{3'd4, 8'hAA, 8'h0F, 8'h5A, 1'b0};
      tbl[5] = '{3'd5, 8'hAA, 8'h0F, 8'hF5, 1'b0};
      tbl[6] = '{3'd6, 8'hAA, 8'h0F, 8'h00, 1'b1};
      tbl[7] = '{3'd7, 8'hAA, 8'h0F, 8'h00, 1'b1};
      wrap_exp = '{3, 1, 3};
      one = 1;

      for (int i = 0; i < N; i++) begin
         r_valid[i] = 1'b0; r_op[i] = '0; r_a[i] = '0; r_b[i] = '0;
      end
      resp_ready = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      m_valid = 0; m_data = '0; m_id = 0; m_err = 0; m_ptr = 0;

      // Reset, then a single request from requester 0.
      reset_dut();
      check("rst_valid", 32'(resp_valid), 0);
      check("rst_data", 32'(resp_data), 0);
      r_valid[0] = 1'b1; r_op[0] = 3'd0; r_a[0] = 8'hF0; r_b[0] = 8'h3C;
      resp_ready = 1'b1;
      #1;
      check("first_ready", 32'(req_ready), 32'h1);
      cycle(g);
      r_valid[0] = 1'b0;
      check("first_valid", 32'(resp_valid), 1);
      check("first_data", 32'(resp_data), 32'h30);
      check("first_id", 32'(resp_id), 0);
      check("first_err", 32'(resp_err), 0);

      // Opcode table through requester 2.
      for (int t = 0; t < 8; t++) begin
         r_valid[2] = 1'b1; r_op[2] = tbl[t].op; r_a[2] = tbl[t].a; r_b[2] = tbl[t].b;
         cycle(g);
         r_valid[2] = 1'b0;
         check("op_data", 32'(resp_data), 32'(tbl[t].exp_data));
         check("op_err", 32'(resp_err), 32'(tbl[t].exp_err));
         check("op_id", 32'(resp_id), 2);
      end
      cycle(g);

      // Round robin with all requesters valid and downstream always ready.
      reset_dut();
      for (int i = 0; i < N; i++) begin
         r_valid[i] = 1'b1; r_op[i] = 3'(i); r_a[i] = 8'(8'h11 * (i + 1)); r_b[i] = 8'h5C;
      end
      resp_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         cycle(g);
         check("rr_valid", 32'(resp_valid), 1);
         check("rr_id", 32'(resp_id), k % N);
      end

      // Back-pressure: five stalled cycles, then retire and refill together.
      resp_ready = 1'b0;
      held_data = resp_data;
      held_id   = int'(resp_id);
      for (int k = 0; k < 5; k++) begin
         #1;
         check("bp_ready", 32'(req_ready), 0);
         cycle(g);
         check("bp_valid", 32'(resp_valid), 1);
         check("bp_data", 32'(resp_data), 32'(held_data));
         check("bp_id", 32'(resp_id), held_id);
      end
      resp_ready = 1'b1;
      nxt = (held_id + 1) % N;
      #1;
      check("bp_release_ready", 32'(req_ready), 32'(one << nxt));
      cycle(g);
      check("bp_release_valid", 32'(resp_valid), 1);
      check("bp_release_id", 32'(resp_id), nxt);

      // Wrap and skip: pointer at 3, only requesters 1 and 3 valid.
      clear_reqs();
      reset_dut();
      for (int i = 0; i < 3; i++) begin
         r_valid[i] = 1'b1;
         cycle(g);
         r_valid[i] = 1'b0;
      end
      r_valid[1] = 1'b1;
      r_valid[3] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cycle(g);
         check("wrap_id", 32'(resp_id), wrap_exp[k]);
      end
      clear_reqs();

      // Reset while a result is stalled.
      for (int i = 0; i < N; i++) r_valid[i] = 1'b1;
      resp_ready = 1'b0;
      cycle(g);
      check("mid_full", 32'(resp_valid), 1);
      rst = 1'b1;
      #1;
      check("mid_rst_ready", 32'(req_ready), 0);
      cycle(g);
      rst = 1'b0;
      check("mid_valid", 32'(resp_valid), 0);
      check("mid_data", 32'(resp_data), 0);
      check("mid_id", 32'(resp_id), 0);
      check("mid_err", 32'(resp_err), 0);
      #1;
      check("mid_next_ready", 32'(req_ready), 32'h1);
      cycle(g);
      check("mid_next_id", 32'(resp_id), 0);

      // Random traffic: requesters hold until granted; fairness is tracked.
      clear_reqs();
      for (int i = 0; i < N; i++) waits[i] = 0;
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!r_valid[i] && ($urandom_range(0, 1) == 1)) begin
               r_valid[i] = 1'b1;
               r_op[i]    = 3'($urandom_range(0, 7));
               r_a[i]     = 8'($urandom);
               r_b[i]     = 8'($urandom);
               waits[i]   = 0;
            end
         end
         resp_ready = ($urandom_range(0, 3) != 0);
         rst = ($urandom_range(0, 199) == 0);
         cycle(g);
         if (rst) begin
            for (int i = 0; i < N; i++) waits[i] = 0;
         end else if (g >= 0) begin
            check("fairness", 32'(waits[g] < N), 1);
            r_valid[g] = 1'b0;
            for (int i = 0; i < N; i++) begin
               if (i != g && r_valid[i]) waits[i]++;
            end
         end
      end
      rst = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
